// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-space arbiter: owner encoding, memory-map bounds
// (common with the mem_space decoder) and address-range helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    localparam logic [15:0] MAP_PER8_BASE  = 16'h0010;
    localparam logic [15:0] MAP_PER16_BASE = 16'h0100;
    localparam logic [15:0] MAP_RAM_BASE   = 16'h0200;
    localparam logic [15:0] MAP_RAM_END    = 16'h0400;
    localparam logic [15:0] MAP_ROM_BASE   = 16'hC000;

    localparam logic [15:0] ERR_RDATA      = 16'h3FFF;

    // Nothing is decoded between the top of RAM and the ROM base.
    function automatic logic addr_unused(input logic [15:0] a);
        return (a >= MAP_RAM_END) && (a < MAP_ROM_BASE);
    endfunction

    function automatic logic addr_rom(input logic [15:0] a);
        return a >= MAP_ROM_BASE;
    endfunction

endpackage

// File: rtl/mem_arb_mux.sv
// Owner-select of the CPU/DMA access onto the memory-space bus, ack decode and read-data
// steering. With MEM_ARB_BUS_ERR_EN defined it also flags accesses outside the memory map.
module mem_arb_mux
    import mem_arb_pkg::*;
(
    input  owner_e      i_owner,
    input  logic        i_cpu_req,
    input  logic [15:0] i_cpu_addr,
    input  logic [15:0] i_cpu_wdata,
    input  logic        i_cpu_we,
    input  logic        i_cpu_bw,
    input  logic        i_dma_req,
    input  logic [15:0] i_dma_addr,
    input  logic [15:0] i_dma_wdata,
    input  logic        i_dma_we,
    input  logic        i_dma_bw,
    input  logic [15:0] i_mem_rdata,
`ifdef MEM_ARB_BUS_ERR_EN
    output logic        o_err,
`endif
    output logic        o_cpu_ack,
    output logic [15:0] o_cpu_rdata,
    output logic        o_dma_ack,
    output logic [15:0] o_dma_rdata,
    output logic [15:0] o_mem_mab,
    output logic [15:0] o_mem_mdb_wr,
    output logic        o_mem_mw,
    output logic        o_mem_bw
);

    logic        w_ack;
    logic        w_we;
    logic        w_err;
    logic [15:0] w_rdata;

    assign o_cpu_ack = (i_owner == OWN_CPU) && i_cpu_req;
    assign o_dma_ack = (i_owner == OWN_DMA) && i_dma_req;
    assign w_ack     = o_cpu_ack | o_dma_ack;

    // The bus follows the owner even when its req has dropped; only MW is gated by ack.
    always_comb begin
        o_mem_mab    = 16'h0000;
        o_mem_mdb_wr = 16'h0000;
        o_mem_bw     = 1'b0;
        w_we         = 1'b0;
        case (i_owner)
            OWN_CPU: begin
                o_mem_mab    = i_cpu_addr;
                o_mem_mdb_wr = i_cpu_wdata;
                o_mem_bw     = i_cpu_bw;
                w_we         = i_cpu_we;
            end
            OWN_DMA: begin
                o_mem_mab    = i_dma_addr;
                o_mem_mdb_wr = i_dma_wdata;
                o_mem_bw     = i_dma_bw;
                w_we         = i_dma_we;
            end
            default: begin
                o_mem_mab    = 16'h0000;
                o_mem_mdb_wr = 16'h0000;
                o_mem_bw     = 1'b0;
                w_we         = 1'b0;
            end
        endcase
    end

`ifdef MEM_ARB_BUS_ERR_EN
    assign w_err = w_ack && (addr_unused(o_mem_mab) || (w_we && addr_rom(o_mem_mab)));
    assign o_err = w_err;
`else
    assign w_err = 1'b0;
`endif

    assign o_mem_mw    = w_we && w_ack && !w_err;
    assign w_rdata     = w_err ? ERR_RDATA : i_mem_rdata;
    assign o_cpu_rdata = o_cpu_ack ? w_rdata : 16'h0000;
    assign o_dma_rdata = o_dma_ack ? w_rdata : 16'h0000;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory-space port between the CPU and one DMA channel: DMA has priority, limited
// by DMA_MAX_BURST so the CPU keeps progressing. MEM_ARB_BUS_ERR_EN adds bus_err/err_addr.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DMA_MAX_BURST = 8,
    parameter int CNT_W         = 8
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_bw,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    input  logic        dma_we,
    input  logic        dma_bw,
    output logic        dma_ack,
    output logic [15:0] dma_rdata,
    output logic [15:0] mem_MAB,
    output logic [15:0] mem_MDB_wr,
    output logic        mem_MW,
    output logic        mem_BW,
    input  logic [15:0] mem_MDB_rd,
`ifdef MEM_ARB_BUS_ERR_EN
    output logic        bus_err,
    output logic [15:0] err_addr,
`endif
    output logic [1:0]  owner
);

    localparam logic [CNT_W-1:0] CNT_LIMIT =
        (DMA_MAX_BURST == 0) ? {CNT_W{1'b1}} : CNT_W'(DMA_MAX_BURST);

    owner_e           r_owner;
    owner_e           w_owner_next;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_force_cpu;

    // The count seen by the force check includes the grant in progress, so the CPU slot
    // follows exactly DMA_MAX_BURST consecutive DMA acks.
    always_comb begin
        w_cnt_next = '0;
        if (r_owner == OWN_DMA) begin
            w_cnt_next = r_burst_cnt;
            if (dma_ack && (r_burst_cnt != CNT_LIMIT)) begin
                w_cnt_next = r_burst_cnt + 1'b1;
            end
        end
    end

    assign w_force_cpu = (DMA_MAX_BURST != 0) && (w_cnt_next == CNT_LIMIT) && cpu_req;

    always_comb begin
        w_owner_next = OWN_IDLE;
        if (dma_req && !w_force_cpu) begin
            w_owner_next = OWN_DMA;
        end else if (cpu_req) begin
            w_owner_next = OWN_CPU;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= OWN_IDLE;
            r_burst_cnt <= '0;
        end else begin
            r_owner     <= w_owner_next;
            r_burst_cnt <= w_cnt_next;
        end
    end

    assign owner = r_owner;

`ifdef MEM_ARB_BUS_ERR_EN
    logic        w_err;
    logic        r_bus_err;
    logic [15:0] r_err_addr;
`endif

    mem_arb_mux u_mux (
        .i_owner      (r_owner),
        .i_cpu_req    (cpu_req),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .i_cpu_we     (cpu_we),
        .i_cpu_bw     (cpu_bw),
        .i_dma_req    (dma_req),
        .i_dma_addr   (dma_addr),
        .i_dma_wdata  (dma_wdata),
        .i_dma_we     (dma_we),
        .i_dma_bw     (dma_bw),
        .i_mem_rdata  (mem_MDB_rd),
`ifdef MEM_ARB_BUS_ERR_EN
        .o_err        (w_err),
`endif
        .o_cpu_ack    (cpu_ack),
        .o_cpu_rdata  (cpu_rdata),
        .o_dma_ack    (dma_ack),
        .o_dma_rdata  (dma_rdata),
        .o_mem_mab    (mem_MAB),
        .o_mem_mdb_wr (mem_MDB_wr),
        .o_mem_mw     (mem_MW),
        .o_mem_bw     (mem_BW)
    );

`ifdef MEM_ARB_BUS_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_err  <= 1'b0;
            r_err_addr <= 16'h0000;
        end else begin
            r_bus_err <= w_err;
            if (w_err) begin
                r_err_addr <= mem_MAB;
            end
        end
    end

    assign bus_err  = r_bus_err;
    assign err_addr = r_err_addr;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural mem_space (RAM below 0x0400, patterned ROM from 0xC000),
// single-transaction vector table, then reset-abort and burst-limit sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clr;
  logic        cpu_req, cpu_we, cpu_bw, dma_req, dma_we, dma_bw;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_ack, dma_ack, mem_MW, mem_BW;
  logic [15:0] cpu_rdata, dma_rdata, mem_MAB, mem_MDB_wr, mem_MDB_rd;
  logic [1:0]  owner;
  logic        cpu_ack_z, dma_ack_z, mem_MW_z, mem_BW_z;
  logic [15:0] cpu_rdata_z, dma_rdata_z, mem_MAB_z, mem_MDB_wr_z;
  logic [15:0] zero_rd = 16'h0000;
  logic [1:0]  owner_z;
`ifdef MEM_ARB_BUS_ERR_EN
  logic        bus_err, bus_err_z;
  logic [15:0] err_addr, err_addr_z;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  logic [1:0]  gnt_q[$];
  logic [15:0] ram [0:511];

  typedef struct {
    logic        dma;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        bw;
    logic        exp_mw;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_arbiter #(.DMA_MAX_BURST(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_bw(cpu_bw), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
    .dma_bw(dma_bw), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_MAB(mem_MAB), .mem_MDB_wr(mem_MDB_wr), .mem_MW(mem_MW), .mem_BW(mem_BW),
    .mem_MDB_rd(mem_MDB_rd),
`ifdef MEM_ARB_BUS_ERR_EN
    .bus_err(bus_err), .err_addr(err_addr),
`endif
    .owner(owner)
  );

  mem_arbiter #(.DMA_MAX_BURST(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_bw(cpu_bw), .cpu_ack(cpu_ack_z), .cpu_rdata(cpu_rdata_z),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
    .dma_bw(dma_bw), .dma_ack(dma_ack_z), .dma_rdata(dma_rdata_z),
    .mem_MAB(mem_MAB_z), .mem_MDB_wr(mem_MDB_wr_z), .mem_MW(mem_MW_z), .mem_BW(mem_BW_z),
    .mem_MDB_rd(zero_rd),
`ifdef MEM_ARB_BUS_ERR_EN
    .bus_err(bus_err_z), .err_addr(err_addr_z),
`endif
    .owner(owner_z)
  );

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return {a[15:1], 1'b0} ^ 16'h5AA5;
  endfunction

  // mem_space stand-in: combinational read, write commits at the clock edge.
  always_comb begin
    mem_MDB_rd = 16'h0000;
    if (mem_MAB >= 16'hC000) mem_MDB_rd = rom_word(mem_MAB);
    else if (mem_MAB < 16'h0400) mem_MDB_rd = ram[mem_MAB[9:1]];
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) ram[i] <= 16'h0000;
    end else if (mem_MW && (mem_MAB < 16'h0400)) begin
      if (!mem_BW) ram[mem_MAB[9:1]] <= mem_MDB_wr;
      else if (mem_MAB[0]) ram[mem_MAB[9:1]][15:8] <= mem_MDB_wr[7:0];
      else ram[mem_MAB[9:1]][7:0] <= mem_MDB_wr[7:0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic dma, input logic [15:0] addr, input logic [15:0] wdata,
                              input logic we, input logic bw, input logic exp_mw,
                              input logic [15:0] exp_rd, input logic exp_err);
    vec_t v;
    v.dma = dma; v.addr = addr; v.wdata = wdata; v.we = we; v.bw = bw;
    v.exp_mw = exp_mw; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic xfer(input vec_t v, input int idx);
    int          lat;
    logic        got;
    logic [15:0] exp;
    logic [1:0]  own;
    own = v.dma ? 2'd2 : 2'd1;
    @(negedge clk);
    if (v.dma) begin
      dma_req = 1'b1; dma_addr = v.addr; dma_wdata = v.wdata; dma_we = v.we; dma_bw = v.bw;
    end else begin
      cpu_req = 1'b1; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_we = v.we; cpu_bw = v.bw;
    end
    if (!v.we) exp_q.push_back(v.exp_rd);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = v.dma ? dma_ack : cpu_ack;
    end
    if (!got) begin
      check($sformatf("v%0d_ack_timeout", idx), 32'd0, 32'd1);
      if (!v.we) void'(exp_q.pop_front());
    end else begin
      check($sformatf("v%0d_latency", idx), lat, 1);
      check($sformatf("v%0d_owner", idx), owner, own);
      check($sformatf("v%0d_other_ack", idx), v.dma ? cpu_ack : dma_ack, 0);
      check($sformatf("v%0d_mab", idx), mem_MAB, v.addr);
      check($sformatf("v%0d_mw", idx), mem_MW, v.exp_mw);
      check($sformatf("v%0d_bw", idx), mem_BW, v.bw);
      if (v.we && v.exp_mw) check($sformatf("v%0d_mdb_wr", idx), mem_MDB_wr, v.wdata);
      if (!v.we) begin
        exp = exp_q.pop_front();
        check($sformatf("v%0d_rdata", idx), v.dma ? dma_rdata : cpu_rdata, exp);
      end
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_drop_owner", idx), owner, own);
    check($sformatf("v%0d_drop_ack", idx), {cpu_ack, dma_ack}, 0);
    check($sformatf("v%0d_drop_mw", idx), mem_MW, 0);
`ifdef MEM_ARB_BUS_ERR_EN
    check($sformatf("v%0d_bus_err", idx), bus_err, v.exp_err);
    if (v.exp_err) check($sformatf("v%0d_err_addr", idx), err_addr, v.addr);
`endif
    @(negedge clk);
    check($sformatf("v%0d_idle_owner", idx), owner, 0);
`ifdef MEM_ARB_BUS_ERR_EN
    check($sformatf("v%0d_bus_err_pulse", idx), bus_err, 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    cpu_req = 1'b1; cpu_addr = 16'h0210; cpu_wdata = 16'h1111; cpu_we = 1'b1; cpu_bw = 1'b1;
    dma_req = 1'b1; dma_addr = 16'h0220; dma_wdata = 16'h2222; dma_we = 1'b1; dma_bw = 1'b1;

    // Reset holds everything idle even with both masters requesting.
    repeat (2) @(negedge clk);
    check("rst_owner", owner, 0);
    check("rst_acks", {cpu_ack, dma_ack}, 0);
    check("rst_mw", mem_MW, 0);
    check("rst_mab", mem_MAB, 0);
    check("rst_mdb_wr", mem_MDB_wr, 0);
    check("rst_bw", mem_BW, 0);
    check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
`ifdef MEM_ARB_BUS_ERR_EN
    check("rst_bus_err", bus_err, 0);
    check("rst_err_addr", err_addr, 0);
`endif
    cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0; cpu_bw = 1'b0; dma_bw = 1'b0;
    mem_clr = 1'b0;
    rst = 1'b0;

    // Reset in the middle of a DMA write must abort it before the committing edge.
    @(negedge clk);
    dma_req = 1'b1; dma_addr = 16'h0200; dma_wdata = 16'hBEEF; dma_we = 1'b1; dma_bw = 1'b0;
    @(negedge clk);
    check("abort_pre_ack", dma_ack, 1);
    check("abort_pre_mw", mem_MW, 1);
    rst = 1'b1;
    #1;
    check("abort_mw", mem_MW, 0);
    check("abort_acks", {cpu_ack, dma_ack}, 0);
    check("abort_owner", owner, 0);
    dma_req = 1'b0; dma_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    vecs.push_back(mk(1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b0, 16'hC000, 16'h0000, 1'b0, 1'b0, 1'b0, rom_word(16'hC000), 1'b0));
    vecs.push_back(mk(1'b0, 16'h0210, 16'hA55A, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0210, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hA55A, 1'b0));
    vecs.push_back(mk(1'b1, 16'h0220, 16'h1357, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b1, 16'h0220, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1357, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0300, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b1, 16'h0301, 16'h00FF, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0300, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFF34, 1'b0));
    vecs.push_back(mk(1'b1, 16'hC002, 16'h0000, 1'b0, 1'b0, 1'b0, rom_word(16'hC002), 1'b0));
    vecs.push_back(mk(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0));
`ifdef MEM_ARB_BUS_ERR_EN
    vecs.push_back(mk(1'b0, 16'hC010, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(1'b0, 16'hC010, 16'h0000, 1'b0, 1'b0, 1'b0, rom_word(16'hC010), 1'b0));
    vecs.push_back(mk(1'b0, 16'h1000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h3FFF, 1'b1));
    vecs.push_back(mk(1'b1, 16'h0500, 16'h4444, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(1'b1, 16'h03FE, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0));
`endif
    for (int i = 0; i < vecs.size(); i++) xfer(vecs[i], i);

    // Both masters request together from idle: DMA first, then 4 DMA / 1 CPU repeating;
    // the unlimited instance never grants the CPU.
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h0210; cpu_we = 1'b0; cpu_bw = 1'b0;
    dma_req = 1'b1; dma_addr = 16'hC000; dma_we = 1'b0; dma_bw = 1'b0;
    for (int k = 0; k < 15; k++) gnt_q.push_back((k % 5 == 4) ? 2'b01 : 2'b10);
    for (int k = 0; k < 15; k++) begin
      logic [1:0] exp_g;
      @(negedge clk);
      exp_g = gnt_q.pop_front();
      check($sformatf("burst_c%0d_grant", k), {dma_ack, cpu_ack}, exp_g);
      if (exp_g == 2'b01) check($sformatf("burst_c%0d_cpu_rdata", k), cpu_rdata, 16'hA55A);
      check($sformatf("burst0_c%0d_grant", k), {dma_ack_z, cpu_ack_z}, 2'b10);
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (2) @(negedge clk);
    check("burst_end_owner", owner, 0);
    check("burst0_end_owner", owner_z, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
